// File: rtl/tabla_scanner_pkg.sv
// Shared definitions for the truth-table scanner and its benches.
// No logic: state encoding and expected truth tables per lab exercise.
// Expected tables: bit i = Y for ABC == i, with A as the MSB of the select vector.
package tabla_scanner_pkg;

    // Scanner FSM state encoding
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam int SETTLE_DEFAULT = 2;

    // 3-input XOR (odd parity): Y = A ^ B ^ C
    localparam logic [7:0] TABLE_XOR3   = 8'b1001_0110;
    // tabla1: Y = A & B (rows 6 and 7 high)
    localparam logic [7:0] TABLE_TABLA1 = 8'b1100_0000;

endpackage

// File: rtl/settle_timer.sv
// Settle-time down counter: load SETTLE-1, decrement to zero, flag zero.
// Latency: o_zero reflects the registered count, so it updates one edge after load/dec.
// No backpressure: i_load wins over i_dec, and the count saturates at zero.
module settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    localparam int W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [W-1:0] LOAD_VAL = W'(SETTLE - 1);

    logic [W-1:0] r_cnt;

    // Load on request, otherwise count down while enabled and not yet at zero
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/tabla_scanner.sv
// Walks every ABC select vector into a mux-based function, samples Y, checks the table.
// Latency: SETTLE+1 cycles per vector; done rises 2**N_IN*(SETTLE+1) edges after start.
// No backpressure: start is ignored while busy and is never queued.
module tabla_scanner
    import tabla_scanner_pkg::*;
#(
    parameter int                  N_IN     = 3,
    parameter int                  SETTLE   = SETTLE_DEFAULT,
    parameter logic [2**N_IN-1:0]  EXPECTED = TABLE_XOR3
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_y_in,
    output logic [N_IN-1:0]      o_abc_out,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2**N_IN-1:0]   o_table_out,
    output logic                 o_match,
    output logic [N_IN-1:0]      o_first_err
);

    localparam int              ROWS     = 2**N_IN;
    localparam logic [N_IN-1:0] LAST_IDX = N_IN'(ROWS - 1);

    state_t            r_state;
    logic [N_IN-1:0]   r_idx;
    logic [ROWS-1:0]   r_table;
    logic              r_busy;
    logic              r_done;
    logic              r_match;
    logic [N_IN-1:0]   r_first_err;

    logic              w_accept;
    logic              w_last;
    logic              w_timer_load;
    logic              w_timer_dec;
    logic              w_settled;
    logic [ROWS-1:0]   w_final_table;
    logic [ROWS-1:0]   w_diff;
    logic [N_IN-1:0]   w_first_err;
    logic              w_match;

    // A new scan is only accepted when no scan is running
    assign w_accept     = i_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last       = (r_idx == LAST_IDX);
    assign w_timer_load = w_accept || ((r_state == ST_SAMPLE) && !w_last);
    assign w_timer_dec  = (r_state == ST_SETTLE);

    settle_timer #(
        .SETTLE (SETTLE)
    ) u_settle_timer (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_load  (w_timer_load),
        .i_dec   (w_timer_dec),
        .o_zero  (w_settled)
    );

    // Table as it will look after the current sample lands, so the final
    // compare includes the last row captured on the same edge
    always_comb begin
        w_final_table        = r_table;
        w_final_table[r_idx] = i_y_in;
    end

    assign w_diff  = w_final_table ^ EXPECTED;
    assign w_match = (w_diff == '0);

    // Priority encode: scan downwards so the lowest mismatching row wins
    always_comb begin
        w_first_err = '0;
        for (int i = ROWS - 1; i >= 0; i--) begin
            if (w_diff[i]) begin
                w_first_err = N_IN'(i);
            end
        end
    end

    // Scan FSM with index counter, capture register and registered results
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_idx       <= '0;
            r_table     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_match     <= 1'b0;
            r_first_err <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        r_state <= ST_SETTLE;
                        r_idx   <= '0;
                        r_table <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                    end
                end
                ST_SETTLE: begin
                    if (w_settled) begin
                        r_state <= ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    r_table <= w_final_table;
                    if (!w_last) begin
                        r_idx   <= r_idx + N_IN'(1);
                        r_state <= ST_SETTLE;
                    end else begin
                        r_state     <= ST_DONE;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_match     <= w_match;
                        r_first_err <= w_first_err;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_abc_out   = r_idx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_table_out = r_table;
    assign o_match     = r_match;
    assign o_first_err = r_first_err;

endmodule

// File: tb/tb_tabla_scanner.sv
// Directed bench for tabla_scanner with default parameters (3 inputs, SETTLE = 2).
// Y is produced by a small truth-table model selected per test, or driven by hand.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_tabla_scanner;
    import tabla_scanner_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       y_in;
    logic [2:0] abc_out;
    logic       busy;
    logic       done;
    logic [7:0] table_out;
    logic       match;
    logic [2:0] first_err;

    int   n_total = 0;
    int   n_pass  = 0;
    int   mode    = 0;   // 0: XOR model, 1: A & B model, 2: hand-driven y_man
    logic y_man   = 1'b0;

    always #5 clk = ~clk;

    tabla_scanner #(
        .N_IN     (3),
        .SETTLE   (2),
        .EXPECTED (TABLE_XOR3)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_start     (start),
        .i_y_in      (y_in),
        .o_abc_out   (abc_out),
        .o_busy      (busy),
        .o_done      (done),
        .o_table_out (table_out),
        .o_match     (match),
        .o_first_err (first_err)
    );

    // Mux implementation under test
    always_comb begin
        case (mode)
            0:       y_in = ^abc_out;
            1:       y_in = abc_out[2] & abc_out[1];
            default: y_in = y_man;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One full scan from a start pulse; checks the per-cycle sweep and the result
    task automatic run_scan(input bit tog, input bit manual, input logic [7:0] exp_tab,
                            input bit exp_m, input logic [2:0] exp_fe);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int c = 0; c < 24; c++) begin
            logic [2:0] v;
            v = 3'(c / 3);
            chk("scan_abc", abc_out, v);
            chk("scan_busy", busy, 1);
            chk("scan_done_early", done, 0);
            if (manual) y_man = (c % 3 == 2) ? ^v : 1'b1;
            if (tog) start = (c % 2 == 1) && (c < 23);
            @(negedge clk);
        end
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_table", table_out, exp_tab);
        chk("end_match", match, exp_m);
        chk("end_first_err", first_err, exp_fe);
    endtask

    initial begin
        // 1. reset with start asserted: everything zero
        reset = 1'b1;
        start = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_abc", abc_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_table", table_out, 0);
        chk("rst_match", match, 0);
        chk("rst_first_err", first_err, 0);
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        // 2. XOR function: full match
        mode = 0;
        run_scan(1'b0, 1'b0, 8'h96, 1'b1, 3'd0);

        // 3. A & B function: mismatch, lowest bad row is 1; results hold in DONE
        mode = 1;
        run_scan(1'b0, 1'b0, 8'hC0, 1'b0, 3'd1);
        repeat (3) @(negedge clk);
        chk("hold_done", done, 1);
        chk("hold_table", table_out, 8'hC0);
        chk("hold_first_err", first_err, 1);

        // 4. start held high: scans accepted at edges 0, 25, 50
        mode  = 0;
        start = 1'b1;
        for (int e = 0; e < 60; e++) begin
            int s;
            int c;
            bit exp_done;
            @(negedge clk);
            s = (e >= 50) ? 50 : (e >= 25) ? 25 : 0;
            c = e - s;
            exp_done = (c == 24);
            chk("b2b_done", done, exp_done);
            chk("b2b_busy", busy, !exp_done);
            chk("b2b_abc", abc_out, exp_done ? 7 : c / 3);
            if (exp_done) chk("b2b_table", table_out, 8'h96);
        end
        start = 1'b0;
        for (int e = 60; e < 75; e++) begin
            @(negedge clk);
            chk("b2b_tail_done", done, e == 74);
        end
        chk("b2b_tail_table", table_out, 8'h96);

        // 4b. start toggled while busy changes nothing
        run_scan(1'b1, 1'b0, 8'h96, 1'b1, 3'd0);

        // 5. reset during the abc = 3 settle window discards the partial table
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_abc", abc_out, 3);
        chk("mid_table", table_out, 8'h06);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_abc", abc_out, 0);
        chk("mid_rst_table", table_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_match", match, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_busy", busy, 0);
        run_scan(1'b0, 1'b0, 8'h96, 1'b1, 3'd0);

        // 6. Y forced high during settle cycles only: capture is unaffected
        mode = 2;
        run_scan(1'b0, 1'b1, 8'h96, 1'b1, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
